// File: rtl/raster_pkg.sv
// ---------------------------------------------------------------------------
// raster_pkg : shared state encoding, colour width default and width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package raster_pkg;

  localparam int COLOUR_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } raster_state_e;

  // Keeps port widths legal when a dimension collapses to one or zero entries.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter : x/y raster position counter with enable and last-pixel flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module raster_counter
  import raster_pkg::*;
#(
  parameter  int H_RES = 160,
  parameter  int V_RES = 120,
  localparam int X_W   = safe_clog2(H_RES),
  localparam int Y_W   = safe_clog2(V_RES)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_W'(H_RES - 1));
  assign w_y_end = (r_y == Y_W'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (!resetn || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;

endmodule

`default_nettype wire

// File: rtl/frame_rasterizer.sv
// ---------------------------------------------------------------------------
// frame_rasterizer : scans one frame in raster order, BG rows then image-ROM rows
// Optional macro RASTER_STALL_EN adds pix_ready back-pressure.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_rasterizer
  import raster_pkg::*;
#(
  parameter  int                H_RES     = 160,
  parameter  int                V_RES     = 120,
  parameter  int                SPLIT_ROW = 92,
  parameter  int                COLOUR_W  = COLOUR_W_DEFAULT,
  parameter  logic [COLOUR_W-1:0] BG_COLOUR = '0,
  localparam int                ROM_AW    = safe_clog2((V_RES - SPLIT_ROW) * H_RES),
  localparam int                X_W       = safe_clog2(H_RES),
  localparam int                Y_W       = safe_clog2(V_RES)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
`ifdef RASTER_STALL_EN
  input  logic                pix_ready,
`endif
  output logic                busy,
  output logic                done,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      pix_x,
  output logic [Y_W-1:0]      pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  output logic                pix_valid
);

  if (SPLIT_ROW > V_RES) begin : g_bad_split
    $error("frame_rasterizer: SPLIT_ROW must not exceed V_RES");
  end

  raster_state_e r_state;
  raster_state_e w_state_nxt;

  logic                w_adv;
  logic                w_issue;
  logic                w_start_acc;
  logic                w_last;
  logic                w_rom_row;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic [ROM_AW-1:0]   r_addr;
  logic                r_pix_valid;
  logic [X_W-1:0]      r_pix_x;
  logic [Y_W-1:0]      r_pix_y;
  logic [COLOUR_W-1:0] w_colour_live;

`ifdef RASTER_STALL_EN
  assign w_adv = pix_ready | ~r_pix_valid;
`else
  assign w_adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_start_acc = 1'b1;
        end
      end
      ST_SCAN: begin
        if (w_adv) begin
          w_issue = 1'b1;
          if (w_last) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_adv) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_start_acc),
    .i_en   (w_issue),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  assign w_rom_row = (int'(w_y) >= SPLIT_ROW);

  // Running ROM address: counts issued image pixels; parks on the final address.
  always_ff @(posedge clk) begin
    if (!resetn || w_start_acc) begin
      r_addr <= '0;
    end else if (w_issue && w_rom_row && !w_last) begin
      r_addr <= r_addr + ROM_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else if (w_adv) begin
      r_pix_valid <= w_issue;
      if (w_issue) begin
        r_pix_x <= w_x;
        r_pix_y <= w_y;
      end
    end
  end

  assign w_colour_live = !r_pix_valid                 ? '0        :
                         (int'(r_pix_y) < SPLIT_ROW)  ? BG_COLOUR : rom_q;

`ifdef RASTER_STALL_EN
  // The address has already moved on while stalled, so rom_q goes stale after
  // the first stalled cycle; keep the colour captured on that cycle.
  logic                r_stalled;
  logic [COLOUR_W-1:0] r_col_hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stalled  <= 1'b0;
      r_col_hold <= '0;
    end else begin
      r_stalled <= r_pix_valid & ~pix_ready;
      if (!r_stalled) r_col_hold <= w_colour_live;
    end
  end

  assign pix_colour = r_stalled ? r_col_hold : w_colour_live;
`else
  assign pix_colour = w_colour_live;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign rom_addr  = r_addr;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_valid = r_pix_valid;

endmodule

`default_nettype wire

// File: tb/tb_frame_rasterizer.sv
// ---------------------------------------------------------------------------
// tb_frame_rasterizer : randomized-ROM scoreboard bench for frame_rasterizer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_rasterizer;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int S  = 92;
  localparam int CW = 24;
  localparam int N  = H * V;
  localparam int AW = 13;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int BOUND = 3 * N + 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic pix_ready;
  logic busy, done, pix_valid;
  logic [AW-1:0] rom_addr, rom_addr_d;
  logic [CW-1:0] rom_q, pix_colour;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  logic s_busy, s_done, s_valid;
  logic [0:0]    s_rom_addr;
  logic [CW-1:0] s_rom_q = '1;
  logic [CW-1:0] s_colour;
  logic [2:0]    s_pix_x;
  logic [1:0]    s_pix_y;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int stall_lo = 0;
  int unsigned seed;

  typedef struct {
    int            x;
    int            y;
    logic [CW-1:0] col;
    int            addr;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] rom_fn(input int a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ seed;
    return h[CW-1:0];
  endfunction

  // Image ROM with one cycle of read latency.
  always @(posedge clk) begin
    rom_q      <= rom_fn(int'(rom_addr));
    rom_addr_d <= rom_addr;
  end

  frame_rasterizer #(
    .H_RES(H), .V_RES(V), .SPLIT_ROW(S), .COLOUR_W(CW), .BG_COLOUR(24'h0)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
`ifdef RASTER_STALL_EN
    .pix_ready(pix_ready),
`endif
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_q(rom_q),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_valid(pix_valid)
  );

  frame_rasterizer #(
    .H_RES(8), .V_RES(4), .SPLIT_ROW(4), .COLOUR_W(CW), .BG_COLOUR(24'h123456)
  ) dut_small (
    .clk(clk), .resetn(resetn), .start(start2),
`ifdef RASTER_STALL_EN
    .pix_ready(1'b1),
`endif
    .busy(s_busy), .done(s_done), .rom_addr(s_rom_addr), .rom_q(s_rom_q),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_colour(s_colour), .pix_valid(s_valid)
  );

`ifdef RASTER_STALL_EN
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_lo > 0) begin
        pix_ready = 1'b0;
        stall_lo  = stall_lo - 1;
      end else begin
        pix_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end
`else
  initial pix_ready = 1'b1;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        e.x = x;
        e.y = y;
        if (y < S) begin
          e.addr = 0;
          e.col  = '0;
        end else begin
          e.addr = (y - S) * H + x;
          e.col  = rom_fn(e.addr);
        end
        q.push_back(e);
      end
    end
  endtask

  // Monitor: each new presentation pops one expected pixel; stalled repeats must be stable.
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b1;
  logic [XW-1:0] prev_x;
  logic [YW-1:0] prev_y;
  logic [CW-1:0] prev_c;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (pix_valid) begin
      checks++;
      if (prev_v && !prev_r) begin
        if (pix_x !== prev_x || pix_y !== prev_y || pix_colour !== prev_c) begin
          errors++;
          $display("FAIL stall_hold actual=(%0d,%0d,%h) required=(%0d,%0d,%h)",
                   pix_x, pix_y, pix_colour, prev_x, prev_y, prev_c);
        end
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra actual=(%0d,%0d) required=none", pix_x, pix_y);
      end else begin
        mon_e = q.pop_front();
        if (int'(pix_x) != mon_e.x || int'(pix_y) != mon_e.y ||
            pix_colour !== mon_e.col || int'(rom_addr_d) != mon_e.addr) begin
          errors++;
          $display("FAIL pixel actual=(%0d,%0d,%h,a%0d) required=(%0d,%0d,%h,a%0d)",
                   pix_x, pix_y, pix_colour, rom_addr_d,
                   mon_e.x, mon_e.y, mon_e.col, mon_e.addr);
        end
      end
      last_valid_cyc = cyc;
    end
    prev_v = pix_valid;
    prev_r = pix_ready;
    prev_x = pix_x;
    prev_y = pix_y;
    prev_c = pix_colour;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, output int dcyc);
    int i;
    dcyc = -1;
    for (i = 0; i < BOUND; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      tick();
    end
    if (dcyc < 0) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_frame(input string name, input bit start_in_done);
    int st, dcyc;
    push_frame();
    start = 1'b1;
    st = cyc;
    tick();
    start = 1'b0;
    chk({name, "_busy_rel1"}, {busy, pix_valid}, 2'b10);
    tick();
    chk({name, "_first_valid_rel2"}, pix_valid, 1'b1);
`ifdef RASTER_STALL_EN
    repeat (100) tick();
    stall_lo = 5;
`endif
    wait_done(name, dcyc);
`ifndef RASTER_STALL_EN
    chk({name, "_done_cycle"}, dcyc - st, N + 2);
    chk({name, "_last_valid_cycle"}, last_valid_cyc - st, N + 1);
`endif
    chk({name, "_pixels_left"}, q.size(), 0);
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_done_single"}, {done, busy}, 2'b00);
    repeat (3) tick();
    chk({name, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int dcyc, st, cnt, addr_bad, sdone;
    bit found;
    seed = $urandom;

    repeat (3) tick();
    chk("reset_outputs", {busy, done, pix_valid, pix_x, pix_y, pix_colour, rom_addr}, 64'd0);
    resetn = 1'b1;
    repeat (5) tick();
    chk("no_autostart", busy, 1'b0);

    run_frame("frameA", 1'b1);

    // Reset in the middle of the frame at pixel (80,50).
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (pix_valid && pix_x == XW'(80) && pix_y == YW'(50)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("midframe_pixel_seen", found, 1'b1);
    resetn = 1'b0;
    q.delete();
    tick();
    chk("reset_midframe", {busy, done, pix_valid, pix_x, pix_y, pix_colour, rom_addr}, 64'd0);
    resetn = 1'b1;
    repeat (4) tick();
    chk("no_restart_after_reset", busy, 1'b0);

    run_frame("frameC", 1'b0);

    // start held high: two frames back to back with one idle cycle.
    push_frame();
    push_frame();
    start = 1'b1;
    tick();
    wait_done("b2b_first", dcyc);
    tick();
    chk("b2b_gap_idle", {busy, done}, 2'b00);
    tick();
    chk("b2b_restart", busy, 1'b1);
    start = 1'b0;
    wait_done("b2b_second", dcyc);
    chk("b2b_pixels_left", q.size(), 0);
    repeat (3) tick();
    chk("b2b_idle_after", busy, 1'b0);

    // All-background configuration.
    start2 = 1'b1;
    st = cyc;
    tick();
    start2 = 1'b0;
    cnt = 0;
    addr_bad = 0;
    sdone = -1;
    for (int r = 1; r <= 40; r++) begin
      if (s_rom_addr != 1'b0) addr_bad++;
      if (s_valid) begin
        if (cnt < 32)
          chk("small_pixel", {s_pix_x, s_pix_y, s_colour},
              {3'(cnt % 8), 2'(cnt / 8), 24'h123456});
        cnt++;
      end
      if (s_done && sdone < 0) sdone = cyc - st;
      tick();
    end
    chk("small_count", cnt, 32);
    chk("small_rom_addr_zero", addr_bad, 0);
    chk("small_done_cycle", sdone, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_rasterizer.md
FRAME_RASTERIZER -- requirements
Module: frame_rasterizer

Interface
REQ-001 SHALL have parameter H_RES, default 160, horizontal pixels per frame.
REQ-002 SHALL have parameter V_RES, default 120, rows per frame.
REQ-003 SHALL have parameter SPLIT_ROW, default 92, first row sourced from the image ROM; rows above use BG_COLOUR.
REQ-004 SHALL have parameter COLOUR_W, default 24, colour bits per pixel.
REQ-005 SHALL have parameter BG_COLOUR, default 0, colour for rows < SPLIT_ROW.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, request one full-frame scan.
REQ-009 SHALL have port busy, output, 1, high from the cycle after accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the last pixel.
REQ-011 SHALL have port rom_addr, output, ROM_AW = $clog2((V_RES-SPLIT_ROW)*H_RES), image ROM address.
REQ-012 SHALL have port rom_q, input, COLOUR_W, ROM data with exactly 1-cycle read latency.
REQ-013 SHALL have port pix_x, output, X_W = $clog2(H_RES), pixel column.
REQ-014 SHALL have port pix_y, output, Y_W = $clog2(V_RES), pixel row.
REQ-015 SHALL have port pix_colour, output, COLOUR_W, pixel colour.
REQ-016 SHALL have port pix_valid, output, 1, pix_x/pix_y/pix_colour are valid this cycle.

Function
REQ-017 SHALL implement states IDLE, SCAN, FLUSH, DONE.
REQ-018 IDLE: start=1 SHALL go to SCAN next cycle with x=0, y=0, rom_addr=0; start in other states SHALL be ignored.
REQ-019 SCAN: each advancing cycle SHALL issue (x,y) to a one-stage pipeline; x wraps H_RES-1 -> 0 and increments y.
REQ-020 Issuing (H_RES-1, V_RES-1) SHALL transition to FLUSH; FLUSH presents the final pixel, then DONE asserts done for one cycle and returns to IDLE.
REQ-021 pix_* SHALL appear one cycle after issue, aligned with rom_q; pix_colour = BG_COLOUR if pix_y < SPLIT_ROW, else rom_q.
REQ-022 rom_addr SHALL equal (y-SPLIT_ROW)*H_RES + x for the issued pixel when y >= SPLIT_ROW, via an incrementing counter (no multiplier), and hold otherwise.
REQ-023 Timing (no stall, N = H_RES*V_RES): start at cycle 0 -> first pix_valid cycle 2, last pix_valid cycle N+1, done cycle N+2.
REQ-024 Every (x,y) SHALL appear exactly once per frame in raster order; no pixel at x=H_RES or y=V_RES.
REQ-025 If SPLIT_ROW == V_RES, rom_addr SHALL stay 0; SPLIT_ROW > V_RES is an elaboration error.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle is accepted.

Reset
REQ-027 resetn=0 at any clk edge, including mid-frame, SHALL force IDLE, x=y=0, rom_addr=0, busy=0, done=0, pix_valid=0, pix_x=pix_y=0, pix_colour=0.
REQ-028 After resetn returns high, no frame starts without a new start.

Configuration
REQ-029 Macro RASTER_STALL_EN SHALL add input pix_ready (1 bit); pix_ready=0 holds state, x, y, rom_addr, and all pix_* outputs; advance only when pix_ready=1 or pix_valid=0.
REQ-030 Without RASTER_STALL_EN, port pix_ready SHALL NOT exist and the pipeline always advances.

Structure
REQ-031 Package raster_pkg SHALL hold the state enum and the COLOUR_W default.
REQ-032 Sub-module raster_counter SHALL implement the x/y wrap counter with enable and last-pixel flag.

Verification
REQ-033 Default params, start pulse -> 19200 pix_valid cycles in raster order, done at cycle 19202, single pulse.
REQ-034 Row 91 -> colour 0, rom_addr held; row 92 x=0 -> rom_addr 0; (159,119) -> rom_addr 4479.
REQ-035 resetn low at pixel (80,50) -> all outputs 0 next cycle; a later start rescans from (0,0).
REQ-036 start held high continuously -> frames back-to-back, one IDLE cycle between done and next busy.
REQ-037 RASTER_STALL_EN, pix_ready low 5 cycles mid-row -> pix_* stable, no pixel lost or duplicated.
REQ-038 H_RES=8, V_RES=4, SPLIT_ROW=4 -> 32 pixels all BG_COLOUR, rom_addr constant 0, done at cycle 34.
